// File: rtl/fsm_burst_pkg.sv
// Shared types and defaults for the burst-read controller slice.
package fsm_burst_pkg;

    // Default width of the burst-length field (max burst = 2**DEF_LEN_W beats).
    localparam int unsigned DEF_LEN_W = 4;

    // Controller states; XXX exists only as a simulation marker and is never assigned.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        READ = 3'b001,
        DLY  = 3'b011,
        DONE = 3'b010,
        ERR  = 3'b100,
        XXX  = 'x
    } state_e;

endpackage

// File: rtl/fsm_burst_rd_if.sv
// Command/target handshake bundle between the issuer/target side and the burst controller.
interface fsm_burst_rd_if
    import fsm_burst_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) ();

    logic             go;
    logic [LEN_W-1:0] len;
    logic             ws;
    logic             abort;
    logic             err_clr;
    logic             rd;
    logic             ds;
    logic             busy;
    logic             err;
    logic [LEN_W-1:0] beat;

    // Issuer/target side: drives requests and wait-state, observes status.
    modport master (
        output go, len, ws, abort, err_clr,
        input  rd, ds, busy, err, beat
    );

    // Controller side.
    modport slave (
        input  go, len, ws, abort, err_clr,
        output rd, ds, busy, err, beat
    );

endinterface

// File: rtl/fsm_wait_timer.sv
// Counts consecutive wait-state cycles; flags the cycle that would exceed MAX_WAIT.
module fsm_wait_timer #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    assign expired = inc && (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

    // Next count: clear wins over increment.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr) begin
            wait_cnt_d = '0;
        end else if (inc) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/fsm_burst_rd.sv
// N-beat read-burst controller with wait-state timeout, sticky error and synchronous abort.
module fsm_burst_rd
    import fsm_burst_pkg::*;
#(
    parameter int unsigned LEN_W    = DEF_LEN_W,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    fsm_burst_rd_if.slave  bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             rd_q, rd_d;
    logic             ds_q, ds_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             timer_clr;
    logic             timer_inc;
    logic             timer_expired;

    // The timer only runs while a beat is stalled in DLY.
    assign timer_clr = (state_q != DLY);
    assign timer_inc = (state_q == DLY) && bus.ws;

    fsm_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // Next-state, burst bookkeeping and output decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d     = READ;
                    remaining_d = bus.len;
                    beat_d      = '0;
                end
            end
            READ: state_d = DLY;
            DLY: begin
                if (timer_expired) begin
                    state_d = ERR;
                end else if (!bus.ws) begin
                    if (remaining_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = READ;
                        remaining_d = remaining_q - LEN_W'(1);
                        beat_d      = beat_q + LEN_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                if (bus.err_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                beat_d      = '0;
            end
        endcase

        // Abort overrides every other transition while a burst is in flight.
        if (bus.abort && (state_q inside {READ, DLY, DONE})) begin
            state_d     = IDLE;
            remaining_d = '0;
            beat_d      = '0;
        end

        // Outputs decoded from the next state so the registered copies track the current state.
        rd_d   = (state_d inside {READ, DLY});
        ds_d   = (state_d == DONE);
        busy_d = (state_d inside {READ, DLY, DONE});
        err_d  = (state_d == ERR);
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beat_q      <= '0;
            rd_q        <= 1'b0;
            ds_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            rd_q        <= rd_d;
            ds_q        <= ds_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd   = rd_q;
    assign bus.ds   = ds_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign bus.beat = beat_q;

endmodule

// File: tb/tb_fsm_burst_rd.sv
// Randomised self-checking bench for fsm_burst_rd against a per-cycle expected trace.
module tb_fsm_burst_rd;
    import fsm_burst_pkg::*;

    localparam int unsigned LEN_W    = 4;
    localparam int unsigned MAX_WAIT = 8;
    localparam int          MAXB     = 1 << LEN_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fsm_burst_rd_if #(.LEN_W(LEN_W)) bus ();

    fsm_burst_rd #(
        .LEN_W    (LEN_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One cycle of the expected trace: inputs to apply and outputs expected in that cycle.
    typedef struct {
        bit go;
        int lenv;
        bit ws;
        bit abort;
        bit err_clr;
        bit rd;
        bit ds;
        bit busy;
        bit err;
        int beat;
        bit chk_beat;
    } step_t;

    step_t plan[$];

    function automatic step_t mk(bit rd, bit ds, bit busy, bit err, int beat, bit chk);
        step_t s;
        s.go = 0; s.lenv = 0; s.ws = 0; s.abort = 0; s.err_clr = 0;
        s.rd = rd; s.ds = ds; s.busy = busy; s.err = err;
        s.beat = beat; s.chk_beat = chk;
        return s;
    endfunction

    // Builds the cycle trace of one burst. waits[b] = ws-high cycles on beat b
    // (>= MAX_WAIT means timeout). abort_dly = -1 aborts in READ, >= 0 in that DLY cycle.
    function automatic void plan_burst(int len, int waits[MAXB], int abort_beat,
                                       int abort_dly, bit go_in_done);
        step_t s;
        int    n_dly;
        s = mk(0, 0, 0, 0, 0, 0);
        s.go = 1; s.lenv = len;
        plan.push_back(s);
        for (int b = 0; b <= len; b++) begin
            s = mk(1, 0, 1, 0, b, 1);
            s.ws = 1'($urandom);
            if (b == abort_beat && abort_dly < 0) begin
                s.abort = 1;
                plan.push_back(s);
                plan.push_back(mk(0, 0, 0, 0, 0, 1));
                plan.push_back(mk(0, 0, 0, 0, 0, 1));
                return;
            end
            plan.push_back(s);
            n_dly = (waits[b] >= int'(MAX_WAIT)) ? int'(MAX_WAIT) : waits[b] + 1;
            for (int i = 0; i < n_dly; i++) begin
                s = mk(1, 0, 1, 0, b, 1);
                s.ws = (i < waits[b]);
                if (b == abort_beat && i == abort_dly) begin
                    s.abort = 1;
                    plan.push_back(s);
                    plan.push_back(mk(0, 0, 0, 0, 0, 1));
                    plan.push_back(mk(0, 0, 0, 0, 0, 1));
                    return;
                end
                plan.push_back(s);
            end
            if (waits[b] >= int'(MAX_WAIT)) begin
                s = mk(0, 0, 0, 1, 0, 0); s.go = 1; s.lenv = len;
                plan.push_back(s);
                plan.push_back(s);
                s = mk(0, 0, 0, 1, 0, 0); s.err_clr = 1;
                plan.push_back(s);
                plan.push_back(mk(0, 0, 0, 0, 0, 0));
                plan.push_back(mk(0, 0, 0, 0, 0, 0));
                return;
            end
        end
        s = mk(0, 1, 1, 0, len, 1);
        s.go = go_in_done; s.lenv = int'($urandom_range(0, MAXB - 1));
        plan.push_back(s);
        plan.push_back(mk(0, 0, 0, 0, 0, 0));
        plan.push_back(mk(0, 0, 0, 0, 0, 0));
    endfunction

    // Plays the trace: compare outputs at each falling edge, then drive that cycle's inputs.
    task automatic run_plan(input string name);
        step_t      s;
        logic [3:0] got, exp;
        for (int i = 0; i < plan.size(); i++) begin
            s = plan[i];
            @(negedge clk);
            got = {bus.rd, bus.ds, bus.busy, bus.err};
            exp = {s.rd, s.ds, s.busy, s.err};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s step %0d {rd,ds,busy,err} got %b want %b", name, i, got, exp);
            end
            if (s.chk_beat) begin
                checks++;
                if (bus.beat !== LEN_W'(s.beat)) begin
                    failures++;
                    $display("FAIL %s step %0d beat got %0d want %0d", name, i, bus.beat, s.beat);
                end
            end
            bus.go = s.go; bus.len = LEN_W'(s.lenv); bus.ws = s.ws;
            bus.abort = s.abort; bus.err_clr = s.err_clr;
        end
        plan.delete();
    endtask

    task automatic idle_inputs();
        bus.go = 0; bus.len = '0; bus.ws = 0; bus.abort = 0; bus.err_clr = 0;
    endtask

    task automatic test_reset();
        logic [LEN_W+3:0] got;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_held outputs got %h want 0", got);
        end
        rst_n = 1;
        @(negedge clk);
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_released outputs got %h want 0", got);
        end
    endtask

    task automatic test_single();
        int w[MAXB] = '{default: 0};
        plan_burst(0, w, -1, 0, 0);
        run_plan("single_beat");
    endtask

    task automatic test_back_to_back();
        int w[MAXB] = '{default: 0};
        plan_burst(3, w, -1, 0, 1);
        run_plan("len3_go_in_done");
        plan_burst(2, w, -1, 0, 0);
        run_plan("len2_followup");
    endtask

    task automatic test_wait_states();
        int w[MAXB] = '{default: 0};
        w[0] = 3;
        plan_burst(1, w, -1, 0, 0);
        run_plan("ws3_beat0");
        w[0] = 0; w[1] = MAX_WAIT - 1;
        plan_burst(1, w, -1, 0, 0);
        run_plan("ws_max_minus1");
    endtask

    task automatic test_timeout();
        int w[MAXB] = '{default: 0};
        w[0] = MAX_WAIT;
        plan_burst(2, w, -1, 0, 0);
        run_plan("timeout_beat0");
        w[0] = 1; w[2] = MAX_WAIT + 3;
        plan_burst(4, w, -1, 0, 0);
        run_plan("timeout_beat2");
    endtask

    task automatic test_abort();
        int w[MAXB] = '{default: 1};
        plan_burst(5, w, 2, 1, 0);
        run_plan("abort_dly_beat2");
        plan_burst(1, w, -1, 0, 0);
        run_plan("after_abort");
        plan_burst(3, w, 1, -1, 0);
        run_plan("abort_read_beat1");
    endtask

    task automatic test_full_len();
        int w[MAXB] = '{default: 0};
        plan_burst(MAXB - 1, w, -1, 0, 0);
        run_plan("full_len");
    endtask

    task automatic test_random();
        int w[MAXB];
        int len, ab, ad, tb;
        for (int n = 0; n < 25; n++) begin
            len = int'($urandom_range(0, MAXB - 1));
            for (int b = 0; b < MAXB; b++) begin
                w[b] = ($urandom_range(0, 9) == 0) ? int'(MAX_WAIT - 1) : int'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) begin
                tb = int'($urandom_range(0, len));
                w[tb] = MAX_WAIT;
            end
            ab = -1; ad = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab = int'($urandom_range(0, len));
                ad = int'($urandom_range(0, 2)) - 1;
            end
            plan_burst(len, w, ab, ad, 1'($urandom));
            run_plan("random");
        end
    endtask

    task automatic test_async_reset();
        logic [LEN_W+3:0] got;
        idle_inputs();
        @(negedge clk);
        bus.go = 1; bus.len = LEN_W'(3);
        @(negedge clk);
        bus.go = 0;
        @(negedge clk);
        @(negedge clk);
        bus.ws = 1;
        @(negedge clk);
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== {4'b1010, LEN_W'(1)}) begin
            failures++;
            $display("FAIL pre_reset_dly outputs got %h want %h", got, {4'b1010, LEN_W'(1)});
        end
        #2 rst_n = 0;
        #1;
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL async_reset outputs got %h want 0", got);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_illegal_state();
        logic [LEN_W+3:0] got;
        int w[MAXB] = '{default: 0};
        idle_inputs();
        @(negedge clk);
        bus.go = 1; bus.len = LEN_W'(2);
        @(negedge clk);
        bus.go = 0; bus.ws = 1;
        @(negedge clk);
        checks++;
        if (bus.rd !== 1'b1) begin
            failures++;
            $display("FAIL pre_illegal rd got %b want 1", bus.rd);
        end
        force dut.state_q = state_e'(3'b111);
        @(posedge clk);
        #1;
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL illegal_state outputs got %h want 0", got);
        end
        release dut.state_q;
        bus.ws = 0;
        @(negedge clk);
        got = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL illegal_recovered outputs got %h want 0", got);
        end
        plan_burst(1, w, -1, 0, 0);
        run_plan("after_illegal");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_abort();
        test_full_len();
        test_random();
        test_async_reset();
        test_illegal_state();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
